debug_scan_slave: RTL and testbench

- Parametrised single-clock successor of the Nios II debug-slave TCK/sysclk pair.
- Multi-channel scan data register:
  - captures one of NUM_CH selectable capture sources plus status bits;
  - shifts serially under strobes already synchronised into clk;
  - on update, presents the shifted word as jdo with per-channel take_action / take_no_action one-cycle pulses.
- Sits between the virtual-JTAG strobe synchroniser and the OCI break/ocimem/trace control logic.

---
 rtl/debug_scan_slave_if.sv | 43 ++++
 rtl/debug_scan_slave.sv | 125 ++++++++++++
 tb/tb_debug_scan_slave.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_scan_slave_if.sv
// Debug scan slave interface.
// Bundles the synchronised JTAG strobes, the capture sources and the scan
// results that pass between the strobe synchroniser and the OCI control
// logic.
//   master : drives strobes, ir_in, tdi and capture sources; reads results
//   slave  : the debug_scan_slave side
interface debug_scan_slave_if #(
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4,
    parameter int DR_W   = 38
);
    logic                       abort;
    logic                       ir_update;
    logic [IR_W-1:0]            ir_in;
    logic                       dr_capture;
    logic                       dr_shift;
    logic                       dr_update;
    logic                       tdi;
    logic [NUM_CH*(DR_W-2)-1:0] cap_data;
    logic [NUM_CH*2-1:0]        cap_status;
    logic                       tdo;
    logic [IR_W-1:0]            ir_out;
    logic [DR_W-1:0]            jdo;
    logic [NUM_CH-1:0]          take_action;
    logic [NUM_CH-1:0]          take_no_action;
    logic                       short_scan;
    logic                       shift_ovf;
    logic                       st_idle;

    modport master (
        output abort, ir_update, ir_in, dr_capture, dr_shift, dr_update, tdi,
               cap_data, cap_status,
        input  tdo, ir_out, jdo, take_action, take_no_action, short_scan,
               shift_ovf, st_idle
    );

    modport slave (
        input  abort, ir_update, ir_in, dr_capture, dr_shift, dr_update, tdi,
               cap_data, cap_status,
        output tdo, ir_out, jdo, take_action, take_no_action, short_scan,
               shift_ovf, st_idle
    );
endinterface

// File: rtl/debug_scan_slave.sv
// Multi-channel debug scan data register, single clock domain.
// Captures the channel selected by the instruction register (data plus two
// status bits), shifts it out LSB first on tdo while shifting tdi in, and on
// update publishes the shifted word on jdo with a one-cycle take_action /
// take_no_action pulse for the selected channel. Scans with the wrong shift
// count produce a short_scan pulse instead and leave jdo untouched.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - debug_scan_slave_if.slave (strobes, capture sources, results)
module debug_scan_slave #(
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4,
    parameter int DR_W   = 38
) (
    input logic              clk,
    input logic              reset,
    debug_scan_slave_if.slave bus
);
    localparam int DW    = DR_W - 2;
    localparam int CNT_W = $clog2(DR_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t            state;
    logic [DR_W-1:0]   sr;
    logic [DR_W-1:0]   jdo;
    logic [IR_W-1:0]   ir_reg;
    logic [CNT_W-1:0]  shift_cnt;
    logic              shift_ovf;
    logic              short_scan;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;

    logic [NUM_CH-1:0] ch_hot;
    logic [DR_W-1:0]   cap_word;
    logic              capture_go;

    // Channel decode. An ir_reg value with no matching channel leaves both
    // the one-hot select and the capture word at zero, so such a channel
    // captures zeros and never pulses.
    always_comb begin
        ch_hot   = '0;
        cap_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_reg == IR_W'(k)) begin
                ch_hot[k] = 1'b1;
                cap_word  = {bus.cap_status[2*k +: 2], bus.cap_data[k*DW +: DW]};
            end
        end
    end

    assign capture_go = bus.dr_capture && (state != UPDATE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sr             <= '0;
            jdo            <= '0;
            ir_reg         <= '0;
            shift_cnt      <= '0;
            shift_ovf      <= 1'b0;
            short_scan     <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            short_scan     <= 1'b0;

            if (bus.ir_update && state == IDLE)
                ir_reg <= bus.ir_in;

            if (bus.abort) begin
                state     <= IDLE;
                shift_cnt <= '0;
            end else if (capture_go) begin
                // Capture from IDLE starts a scan; from SHIFT it restarts one.
                sr        <= cap_word;
                shift_cnt <= '0;
                shift_ovf <= 1'b0;
                state     <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (bus.dr_update) begin
                            state <= UPDATE;
                        end else if (bus.dr_shift) begin
                            sr <= {bus.tdi, sr[DR_W-1:1]};
                            // Counter parks at DR_W; any further shift is an
                            // overrun recorded in the sticky flag.
                            if (shift_cnt == CNT_FULL)
                                shift_ovf <= 1'b1;
                            else
                                shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                    UPDATE: begin
                        state <= IDLE;
                        if (shift_cnt == CNT_FULL && !shift_ovf) begin
                            jdo <= sr;
                            if (sr[DR_W-1])
                                take_action    <= ch_hot;
                            else
                                take_no_action <= ch_hot;
                        end else begin
                            short_scan <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.tdo            = sr[0];
    assign bus.ir_out         = ir_reg;
    assign bus.jdo            = jdo;
    assign bus.take_action    = take_action;
    assign bus.take_no_action = take_no_action;
    assign bus.short_scan     = short_scan;
    assign bus.shift_ovf      = shift_ovf;
    assign bus.st_idle        = (state == IDLE);
endmodule

// File: tb/tb_debug_scan_slave.sv
// Testbench for debug_scan_slave: directed scans, a table of strobe
// corner cases, a NUM_CH=3 instance for the out-of-range channel, and
// randomized scans compared every cycle against a behavioural model.
module tb_debug_scan_slave;
    localparam int IR_W   = 2;
    localparam int NUM_CH = 4;
    localparam int DR_W   = 38;
    localparam int DW     = DR_W - 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic s_abort = 1'b0, s_ir_update = 1'b0, s_dr_capture = 1'b0;
    logic s_dr_shift = 1'b0, s_dr_update = 1'b0, s_tdi = 1'b0;
    logic [IR_W-1:0]        s_ir_in      = '0;
    logic [NUM_CH*DW-1:0]   s_cap_data   = '0;
    logic [NUM_CH*2-1:0]    s_cap_status = '0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    debug_scan_slave_if #(.IR_W(IR_W), .NUM_CH(NUM_CH), .DR_W(DR_W)) bus4 ();
    debug_scan_slave_if #(.IR_W(IR_W), .NUM_CH(3),      .DR_W(DR_W)) bus3 ();

    assign bus4.abort      = s_abort;
    assign bus4.ir_update  = s_ir_update;
    assign bus4.ir_in      = s_ir_in;
    assign bus4.dr_capture = s_dr_capture;
    assign bus4.dr_shift   = s_dr_shift;
    assign bus4.dr_update  = s_dr_update;
    assign bus4.tdi        = s_tdi;
    assign bus4.cap_data   = s_cap_data;
    assign bus4.cap_status = s_cap_status;

    assign bus3.abort      = s_abort;
    assign bus3.ir_update  = s_ir_update;
    assign bus3.ir_in      = s_ir_in;
    assign bus3.dr_capture = s_dr_capture;
    assign bus3.dr_shift   = s_dr_shift;
    assign bus3.dr_update  = s_dr_update;
    assign bus3.tdi        = s_tdi;
    assign bus3.cap_data   = s_cap_data[3*DW-1:0];
    assign bus3.cap_status = s_cap_status[5:0];

    debug_scan_slave #(.IR_W(IR_W), .NUM_CH(NUM_CH), .DR_W(DR_W)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));
    debug_scan_slave #(.IR_W(IR_W), .NUM_CH(3), .DR_W(DR_W)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference (NUM_CH=4 instance) ----------
    // phase: 0 idle, 1 scanning, 2 update pending. The shift count is kept
    // unbounded; a scan is good only when exactly DR_W bits went through.
    int               m_phase, m_cnt, m_ir;
    logic [DR_W-1:0]  m_sr, m_jdo;
    logic [NUM_CH-1:0] m_ta, m_tna;
    logic             m_short, m_ovf;

    function automatic logic [DR_W-1:0] cap_src(input int ch);
        if (ch >= NUM_CH) return '0;
        return {s_cap_status[2*ch +: 2], s_cap_data[ch*DW +: DW]};
    endfunction

    always @(posedge clk or posedge reset) begin
        int ir_prev;
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_ir = 0; m_sr = '0; m_jdo = '0;
            m_ta = '0; m_tna = '0; m_short = 1'b0; m_ovf = 1'b0;
        end else begin
            ir_prev = m_ir;
            m_ta = '0; m_tna = '0; m_short = 1'b0;
            if (s_ir_update && m_phase == 0) m_ir = int'(s_ir_in);
            if (s_abort) begin
                m_phase = 0; m_cnt = 0;
            end else if (s_dr_capture && m_phase != 2) begin
                m_sr = cap_src(ir_prev); m_cnt = 0; m_ovf = 1'b0; m_phase = 1;
            end else if (m_phase == 1 && s_dr_update) begin
                m_phase = 2;
            end else if (m_phase == 1 && s_dr_shift) begin
                m_sr = (m_sr >> 1) + (s_tdi ? (38'd1 << (DR_W-1)) : 38'd0);
                m_cnt++;
                if (m_cnt > DR_W) m_ovf = 1'b1;
            end else if (m_phase == 2) begin
                m_phase = 0;
                if (m_cnt == DR_W) begin
                    m_jdo = m_sr;
                    if (ir_prev < NUM_CH) begin
                        if (m_sr[DR_W-1]) m_ta[ir_prev] = 1'b1;
                        else              m_tna[ir_prev] = 1'b1;
                    end
                end else begin
                    m_short = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset)
            check("model",
                  {12'd0, bus4.jdo, bus4.take_action, bus4.take_no_action, bus4.short_scan,
                   bus4.shift_ovf, bus4.st_idle, bus4.tdo, bus4.ir_out},
                  {12'd0, m_jdo, m_ta, m_tna, m_short, m_ovf, (m_phase == 0), m_sr[0],
                   IR_W'(m_ir)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        s_abort = 0; s_ir_update = 0; s_dr_capture = 0;
        s_dr_shift = 0; s_dr_update = 0; s_tdi = 0;
    endtask

    task automatic scan(input logic [DR_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            s_dr_shift = 1'b1;
            s_tdi = (i < DR_W) ? w[i] : 1'b0;
            step();
        end
    endtask

    task automatic expect_update(input string name, input logic [3:0] ta, input logic [3:0] tna,
                                 input logic sh, input logic [DR_W-1:0] jnew,
                                 input logic [DR_W-1:0] jold);
        s_dr_update = 1'b1;
        step();
        check({name, "_early_pulse"},
              {bus4.take_action, bus4.take_no_action, bus4.short_scan}, 9'd0);
        check({name, "_early_jdo"}, bus4.jdo, jold);
        step();
        check({name, "_pulse"},
              {bus4.take_action, bus4.take_no_action, bus4.short_scan}, {ta, tna, sh});
        check({name, "_jdo"}, bus4.jdo, jnew);
        step();
        check({name, "_pulse_end"},
              {bus4.take_action, bus4.take_no_action, bus4.short_scan}, 9'd0);
    endtask

    typedef struct packed {
        logic ab, iu; logic [1:0] ii; logic cap, sh, up;
        logic e_idle; logic [1:0] e_ir; logic e_short; logic e_pulse;
    } vec_t;

    initial begin
        logic [DR_W-1:0] w;
        vec_t tbl[17];
        int lens[7] = '{36, 37, 38, 38, 38, 39, 40};
        int n;

        //            ab iu ii    cap sh up  idle ir    sht pls
        tbl[0]  = '{1'b0,1'b1,2'd2,1'b0,1'b0,1'b0, 1'b1,2'd2,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,2'd1,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,1'b0, 1'b0,2'd1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,2'd3,1'b0,1'b0,1'b0, 1'b0,2'd1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,1'b1, 1'b0,2'd1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,2'd0,1'b0,1'b1,1'b0, 1'b0,2'd1,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b1, 1'b0,2'd1,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b1, 1'b1,2'd1,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,2'd0,1'b0,1'b1,1'b0, 1'b1,2'd1,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,2'd0,1'b1,1'b0,1'b0, 1'b0,2'd1,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,2'd0,1'b1,1'b0,1'b0, 1'b1,2'd1,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,2'd0,1'b1,1'b0,1'b0, 1'b0,2'd1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b1, 1'b0,2'd1,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b0,2'd0,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b0,2'd0,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b0,1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_idle", bus4.st_idle, 1'b1);
        check("rst_jdo", bus4.jdo, 38'd0);
        check("rst_tdo_ovf_ir", {bus4.tdo, bus4.shift_ovf, bus4.ir_out}, 4'd0);
        check("rst_pulses", {bus4.take_action, bus4.take_no_action, bus4.short_scan}, 9'd0);
        chk_en = 1'b1;

        // capture / shift-out on channel 1
        for (int k = 0; k < NUM_CH*DW; k++) s_cap_data[k] = 1'($urandom);
        s_cap_data[1*DW +: DW] = 36'h1_2345_6789;
        s_cap_status = 8'b0000_1000;
        s_ir_update = 1'b1; s_ir_in = 2'd1;
        step();
        check("ir_load", bus4.ir_out, 2'd1);
        s_dr_capture = 1'b1;
        step();
        check("cap_state", bus4.st_idle, 1'b0);
        w = 38'h2_1234_56789;
        for (int i = 0; i < DR_W; i++) begin
            check($sformatf("shiftout_%0d", i), bus4.tdo, w[i]);
            s_dr_shift = 1'b1; s_tdi = 1'b0;
            step();
        end
        check("shiftout_empty", {bus4.tdo, bus4.shift_ovf}, 2'b00);
        expect_update("zero_scan", 4'b0000, 4'b0010, 1'b0, 38'd0, 38'd0);

        // full action scan
        s_dr_capture = 1'b1; step();
        w = 38'h20_0000_00AB;
        scan(w, DR_W);
        expect_update("action", 4'b0010, 4'b0000, 1'b0, w, 38'd0);

        // reset in the middle of a scan
        s_dr_capture = 1'b1; step();
        scan(38'h15_5555_5555, 5);
        #2 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_idle", bus4.st_idle, 1'b1);
        check("midrst_jdo", bus4.jdo, 38'd0);
        check("midrst_tdo_ovf", {bus4.tdo, bus4.shift_ovf}, 2'b00);
        check("midrst_pulses", {bus4.take_action, bus4.take_no_action, bus4.short_scan}, 9'd0);
        reset = 1'b0;
        s_ir_update = 1'b1; s_ir_in = 2'd1; step();

        // short and long scans
        w = 38'h3F_FFFF_FFFF;
        s_dr_capture = 1'b1; step();
        scan(w, 37);
        expect_update("short37", 4'b0, 4'b0, 1'b1, 38'd0, 38'd0);
        s_dr_capture = 1'b1; step();
        scan(w, 38);
        check("ovf_at_38", bus4.shift_ovf, 1'b0);
        scan(w, 1);
        check("ovf_at_39", bus4.shift_ovf, 1'b1);
        expect_update("long39", 4'b0, 4'b0, 1'b1, 38'd0, 38'd0);
        check("ovf_sticky", bus4.shift_ovf, 1'b1);
        s_dr_capture = 1'b1; step();
        check("ovf_cleared", bus4.shift_ovf, 1'b0);
        s_abort = 1'b1; step();

        // strobe priority / IR gating table
        foreach (tbl[i]) begin
            s_abort = tbl[i].ab; s_ir_update = tbl[i].iu; s_ir_in = tbl[i].ii;
            s_dr_capture = tbl[i].cap; s_dr_shift = tbl[i].sh; s_dr_update = tbl[i].up;
            step();
            check($sformatf("tbl_%0d", i),
                  {bus4.st_idle, bus4.ir_out, bus4.short_scan,
                   |{bus4.take_action, bus4.take_no_action}},
                  {tbl[i].e_idle, tbl[i].e_ir, tbl[i].e_short, tbl[i].e_pulse});
        end

        // capture beats update and restarts the bit count
        s_dr_capture = 1'b1; step();
        scan(38'h2A_5A5A_A5A5, 20);
        s_dr_capture = 1'b1; s_dr_update = 1'b1; step();
        check("cap_wins_state", bus4.st_idle, 1'b0);
        w = 38'h0F_FFFF_0000;
        scan(w, DR_W);
        expect_update("restart", 4'b0000, 4'b0010, 1'b0, w, 38'd0);

        // channel 3: in range for dut4, out of range for the NUM_CH=3 dut3
        for (int k = 0; k < NUM_CH; k++) s_cap_data[k*DW] = 1'b1;
        s_cap_status = 8'b1111_1111;
        s_ir_update = 1'b1; s_ir_in = 2'd3; step();
        check("ch3_ir", {bus4.ir_out, bus3.ir_out}, 4'b1111);
        s_dr_capture = 1'b1; step();
        check("ch3_cap_tdo", {bus4.tdo, bus3.tdo}, 2'b10);
        w = 38'h2A_AAAA_5555;
        scan(w, DR_W);
        s_dr_update = 1'b1; step(); step();
        check("oor_pulses", {bus3.take_action, bus3.take_no_action, bus3.short_scan}, 7'd0);
        check("oor_jdo", bus3.jdo, w);
        check("ch3_action", bus4.take_action, 4'b1000);
        step();

        // randomized scans against the model
        for (int s = 0; s < 50; s++) begin
            for (int k = 0; k < NUM_CH*DW; k++) s_cap_data[k] = 1'($urandom);
            for (int k = 0; k < NUM_CH*2; k++)  s_cap_status[k] = 1'($urandom);
            if ($urandom % 3 == 0) begin
                s_ir_update = 1'b1; s_ir_in = 2'($urandom); step();
            end
            s_dr_capture = 1'b1; step();
            n = lens[$urandom % 7];
            for (int i = 0; i < n; i++) begin
                if ($urandom % 8 == 0) step();
                s_dr_shift = 1'b1; s_tdi = 1'($urandom);
                if ($urandom % 60 == 0) s_abort = 1'b1;
                if ($urandom % 60 == 0) s_dr_capture = 1'b1;
                if ($urandom % 10 == 0) begin s_ir_update = 1'b1; s_ir_in = 2'($urandom); end
                step();
            end
            s_dr_update = 1'b1;
            if ($urandom % 10 == 0) s_dr_capture = 1'b1;
            step(); step(); step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
